// File: rtl/regfile_dump_if.sv
// rtl/regfile_dump_if.sv - word stream from regfile_dump to its consumer
//
// out_valid : word on out_data/out_index is valid (source -> sink)
// out_ready : sink accepts the word on this edge   (sink -> source)
// out_data  : dumped register value
// out_index : register index of out_data
interface regfile_dump_if;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_index;

    modport master (
        output out_valid,
        output out_data,
        output out_index,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_index,
        output out_ready
    );
endinterface

// File: rtl/regfile_dump.sv
// rtl/regfile_dump.sv - sequential register-file dumper with XOR signature
//
// clk       : rising-edge clock
// rst       : synchronous reset, active-high
// start     : one-cycle dump request, taken only when idle
// abort     : cancel a running dump
// freeze    : hold pipeline fetch/writeback while a dump is active
// rd_addr   : register index driven to the spare read port
// rd_data   : combinational read data for rd_addr
// out_if    : word stream (out_valid/out_ready/out_data/out_index)
// busy      : dump in progress
// done      : one-cycle pulse after the final word is accepted
// signature : XOR of all words accepted in the current dump
module regfile_dump #(
    parameter int FIRST_REG     = 0,
    parameter int LAST_REG      = 31,
    parameter int SETTLE_CYCLES = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    output logic                  freeze,
    output logic [4:0]            rd_addr,
    input  logic [31:0]           rd_data,
    regfile_dump_if.master        out_if,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           signature
);

    localparam logic [4:0] FIRST_IDX   = 5'(FIRST_REG);
    localparam logic [4:0] LAST_IDX    = 5'(LAST_REG);
    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_READ,
        S_HOLD,
        S_FIN
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  settle_cnt;
    logic [31:0] data_q;
    logic [4:0]  index_q;
    logic        accept;
    logic        last_word;

    // out_valid is exactly "in HOLD", so the handshake reduces to HOLD & ready.
    assign accept    = (state == S_HOLD) && out_if.out_ready;
    assign last_word = (index_q == LAST_IDX);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_SETTLE;
            S_SETTLE: if (settle_cnt == 4'd0) state_nxt = S_READ;
            S_READ:   state_nxt = S_HOLD;
            S_HOLD:   if (accept) state_nxt = last_word ? S_FIN : S_READ;
            S_FIN:    state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
        // abort outranks every transition out of a busy state; in IDLE
        // it is ignored so a simultaneous start still begins a dump.
        if (abort && (state != S_IDLE)) begin
            state_nxt = S_IDLE;
        end
    end

    // Outputs decoded from state. freeze and busy cover the same span:
    // from the edge after start through FIN, dropping on the edge that
    // returns to IDLE (normal end, abort or reset).
    always_comb begin
        busy             = (state != S_IDLE);
        freeze           = (state != S_IDLE);
        done             = (state == S_FIN);
        out_if.out_valid = (state == S_HOLD);
        out_if.out_data  = data_q;
        out_if.out_index = index_q;
    end

    // Datapath: settle counter, read address, captured word and signature
    always_ff @(posedge clk) begin
        if (rst) begin
            settle_cnt <= 4'd0;
            rd_addr    <= FIRST_IDX;
            data_q     <= 32'd0;
            index_q    <= 5'd0;
            signature  <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        settle_cnt <= SETTLE_INIT;
                        rd_addr    <= FIRST_IDX;
                        signature  <= 32'd0;
                    end
                end
                S_SETTLE: begin
                    if (settle_cnt != 4'd0) begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                S_READ: begin
                    if (!abort) begin
                        // x0 is architecturally zero regardless of what the
                        // storage behind the read port returns.
                        data_q  <= (rd_addr == 5'd0) ? 32'd0 : rd_data;
                        index_q <= rd_addr;
                    end
                end
                S_HOLD: begin
                    if (accept && !abort) begin
                        signature <= signature ^ data_q;
                        // Stop at LAST_REG: rd_addr never runs past the window.
                        if (!last_word) begin
                            rd_addr <= rd_addr + 5'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/regfile_dump.md
Name: regfile_dump

Overview:
- Sequential reader for the 32x32 integer register file: on request, freezes the pipeline, walks register indices FIRST_REG..LAST_REG on a spare read-address port, and streams each value out over a valid/ready handshake.
- Sits beside the register file, driving one read-address port and sampling the matching combinational read-data.
- Used for debug snapshots and end-of-test state checking.
- Also produces a running XOR signature of all dumped words.

Parameters:
- FIRST_REG, 0, first register index dumped (0..31).
- LAST_REG, 31, last register index dumped (FIRST_REG..31).
- SETTLE_CYCLES, 3, cycles waited after freeze asserts so in-flight writebacks retire before the first read (1..15).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  one-cycle dump request; honoured only in IDLE.
- abort  input  1  cancel the dump; returns to IDLE next edge.
- freeze  output  1  asks the pipeline to hold fetch/writeback while a dump is active.
- rd_addr  output  5  register index to the register-file read port.
- rd_data  input  32  combinational read data for rd_addr (index 0 reads zero).
- out_valid  output  1  out_data/out_index hold a valid word.
- out_ready  input  1  consumer accepts the word.
- out_data  output  32  dumped register value.
- out_index  output  5  index of out_data.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when the final word is accepted.
- signature  output  32  XOR of all words accepted in the current dump; stable until the next start.

Behaviour:
- Reset (rst high at an edge, in any state, including mid-dump): state=IDLE; freeze, busy, done and out_valid=0; rd_addr=FIRST_REG; out_data, out_index and signature=0; settle counter=0.
- States: IDLE, SETTLE, READ, HOLD, FIN.
- IDLE:
  - start=1 -> SETTLE; freeze=1; settle counter=SETTLE_CYCLES-1; signature=0; rd_addr=FIRST_REG.
  - start while busy is ignored.
- SETTLE:
  - Counter decrements each cycle.
  - At 0 -> READ.
  - The first READ therefore occurs exactly SETTLE_CYCLES cycles after the start edge.
- READ (one cycle):
  - out_data<=rd_data; out_index<=rd_addr; out_valid<=1.
  - Next state is HOLD.
- HOLD:
  - out_valid stays 1; out_data and out_index stay stable while out_ready=0.
  - On out_valid&out_ready: out_valid<=0; signature<=signature^out_data.
  - If out_index==LAST_REG -> FIN; otherwise rd_addr<=rd_addr+1 and go to READ.
  - Throughput is one word per 2 cycles when out_ready is held high.
- FIN (one cycle):
  - done=1; freeze<=0.
  - Next state is IDLE; busy falls in IDLE.
- freeze:
  - Asserted from the edge after start through FIN inclusive.
  - Deasserts on the edge leaving FIN, on abort, or on reset.
- abort:
  - Highest priority after rst, in any non-IDLE state.
  - Next edge: IDLE; out_valid=0; freeze=0; no done pulse; signature holds its partial value.
  - abort in IDLE has no effect.
- Simultaneous events:
  - start and abort together in IDLE: start wins.
  - rst overrides everything.
- rd_addr never exceeds LAST_REG; no wrap-around.
- Index 0 is dumped as 0, whatever the register file's storage holds.
- Register-file writes land on the falling edge, so data sampled on the rising edge in READ is the settled value.

Test Plan:
- Preload reg[n]=0x1000_0000+n; SETTLE_CYCLES=3; out_ready tied 1; pulse start.
  - Required: freeze=1 for the whole dump.
  - Required: 32 words, indices 0..31 in order, data 0,0x10000001..0x1000001F.
  - Required: done pulses once; signature equals the XOR of all 32 words.
  - Required: total time start->done is 3+64 cycles.
- out_ready toggled 0,0,1 per word.
  - Required: out_data/out_index stable while ready=0, no duplicate or skipped indices, and the same signature as the previous test.
- FIRST_REG=5, LAST_REG=7; reg5=0xA, reg6=0xB, reg7=0xC.
  - Required: exactly 3 words, signature 0xA^0xB^0xC=0xD, then done.
- Assert abort during HOLD of index 10.
  - Required next cycle: IDLE, out_valid=0, freeze=0, no done.
  - Required: a new start restarts at FIRST_REG with signature cleared.
- Assert rst during READ of index 20.
  - Required next cycle: all outputs at their reset values (rd_addr=FIRST_REG, everything else 0).
- Pulse start again while busy (mid-dump), and pulse start and abort together in IDLE.
  - Required: the mid-dump start is ignored and the dump continues unaffected.
  - Required: the simultaneous start+abort in IDLE enters SETTLE.
